// File: rtl/pcileech_ft601_device_bfm.sv
// pcileech_ft601_device_bfm: chip-side model of the FT601 245-synchronous FIFO bus.
// Host words are queued toward the FPGA; FPGA writes are queued toward the host.
module pcileech_ft601_device_bfm #(
    parameter int RX_DEPTH_LOG2 = 10,
    parameter int TX_DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ft601_data_in,
    output logic [31:0] ft601_data_out,
    output logic        ft601_data_oe,
    input  logic [3:0]  ft601_be_in,
    output logic [3:0]  ft601_be_out,
    output logic        ft601_rxf_n,
    output logic        ft601_txe_n,
    input  logic        ft601_wr_n,
    input  logic        ft601_rd_n,
    input  logic        ft601_oe_n,
    input  logic        ft601_siwu_n,
    input  logic [31:0] host_in_data,
    input  logic        host_in_valid,
    output logic        host_in_ready,
    output logic [35:0] host_out_data,
    output logic        host_out_valid,
    input  logic        host_out_ready,
    output logic        err_underrun,
    output logic        err_overrun,
    output logic        err_contention,
    output logic [31:0] cnt_rd,
    output logic [31:0] cnt_wr
);
    localparam int RN = RX_DEPTH_LOG2;
    localparam int TN = TX_DEPTH_LOG2;

    logic [31:0] rx_mem [2**RN];
    logic [35:0] tx_mem [2**TN];
    logic [RN:0] rx_wp, rx_rp, rx_wp_nx, rx_rp_nx;
    logic [TN:0] tx_wp, tx_rp, tx_wp_nx, tx_rp_nx;
    logic        rx_empty, rx_push, rx_pop, rx_full_nx;
    logic        tx_push, tx_pop, tx_full_nx;
    logic        rd_req;
    logic [31:0] head_nx;
    logic        unused_siwu;

    assign unused_siwu  = ft601_siwu_n;
    assign ft601_be_out = 4'hF;

    assign rd_req   = !ft601_rd_n && !ft601_oe_n;
    assign rx_empty = rx_wp == rx_rp;
    assign rx_push  = host_in_valid && host_in_ready;
    assign rx_pop   = rd_req && !rx_empty;
    assign rx_wp_nx = rx_wp + (RN+1)'(rx_push);
    assign rx_rp_nx = rx_rp + (RN+1)'(rx_pop);
    assign rx_full_nx = (rx_wp_nx[RN] != rx_rp_nx[RN]) && (rx_wp_nx[RN-1:0] == rx_rp_nx[RN-1:0]);
    // The word being pushed this cycle bypasses the array when it becomes the new head.
    assign head_nx = (rx_rp_nx == rx_wp) ? (rx_push ? host_in_data : ft601_data_out)
                                         : rx_mem[rx_rp_nx[RN-1:0]];

    assign host_out_valid = tx_wp != tx_rp;
    assign host_out_data  = tx_mem[tx_rp[TN-1:0]];
    assign tx_push  = !ft601_wr_n && !ft601_txe_n;
    assign tx_pop   = host_out_valid && host_out_ready;
    assign tx_wp_nx = tx_wp + (TN+1)'(tx_push);
    assign tx_rp_nx = tx_rp + (TN+1)'(tx_pop);
    assign tx_full_nx = (tx_wp_nx[TN] != tx_rp_nx[TN]) && (tx_wp_nx[TN-1:0] == tx_rp_nx[TN-1:0]);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[RN-1:0]] <= host_in_data;
        if (tx_push) tx_mem[tx_wp[TN-1:0]] <= {ft601_be_in, ft601_data_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp          <= '0;
            rx_rp          <= '0;
            tx_wp          <= '0;
            tx_rp          <= '0;
            ft601_data_out <= '0;
            ft601_data_oe  <= 1'b0;
            ft601_rxf_n    <= 1'b1;
            ft601_txe_n    <= 1'b1;
            host_in_ready  <= 1'b0;
            err_underrun   <= 1'b0;
            err_overrun    <= 1'b0;
            err_contention <= 1'b0;
            cnt_rd         <= '0;
            cnt_wr         <= '0;
        end else begin
            rx_wp          <= rx_wp_nx;
            rx_rp          <= rx_rp_nx;
            tx_wp          <= tx_wp_nx;
            tx_rp          <= tx_rp_nx;
            ft601_data_out <= head_nx;
            ft601_data_oe  <= !ft601_oe_n;
            ft601_rxf_n    <= rx_wp_nx == rx_rp_nx;
            ft601_txe_n    <= tx_full_nx;
            host_in_ready  <= !rx_full_nx;
            err_underrun   <= err_underrun || (rd_req && rx_empty);
            err_overrun    <= err_overrun || (!ft601_wr_n && ft601_txe_n);
            err_contention <= err_contention || (!ft601_wr_n && ft601_data_oe);
            cnt_rd         <= cnt_rd + 32'(rx_pop);
            cnt_wr         <= cnt_wr + 32'(tx_push);
        end
    end
endmodule

// File: tb/tb_pcileech_ft601_device_bfm.sv
// tb_pcileech_ft601_device_bfm: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the FT601 device end.
module tb_pcileech_ft601_device_bfm;
    localparam int RXD = 16;
    localparam int TXD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0, data_out, host_in_data = '0, cnt_rd, cnt_wr;
    logic [3:0]  be_in = 4'h0, be_out;
    logic        data_oe, rxf_n, txe_n, host_in_ready, host_out_valid;
    logic        wr_n = 1'b1, rd_n = 1'b1, oe_n = 1'b1, host_in_valid = 1'b0, host_out_ready = 1'b0;
    logic        err_underrun, err_overrun, err_contention;
    logic [35:0] host_out_data;

    always #5 clk = ~clk;

    pcileech_ft601_device_bfm #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ft601_data_in(data_in), .ft601_data_out(data_out), .ft601_data_oe(data_oe),
        .ft601_be_in(be_in), .ft601_be_out(be_out),
        .ft601_rxf_n(rxf_n), .ft601_txe_n(txe_n),
        .ft601_wr_n(wr_n), .ft601_rd_n(rd_n), .ft601_oe_n(oe_n), .ft601_siwu_n(1'b1),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
        .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .err_underrun(err_underrun), .err_overrun(err_overrun), .err_contention(err_contention),
        .cnt_rd(cnt_rd), .cnt_wr(cnt_wr)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rxq[$];
    logic [35:0] txq[$];
    logic        m_rxf_n, m_txe_n, m_oe, m_hready, m_under, m_over, m_cont;
    logic [31:0] m_dout, m_cnt_rd, m_cnt_wr;

    typedef struct {
        logic        hv;
        logic [31:0] hd;
        logic        oe_n;
        logic        rd_n;
        logic        e_rxf_n;
        logic        e_oe;
        logic [31:0] e_dout;
        logic [31:0] e_cnt;
        logic        e_under;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rxf_n = 1'b1; m_txe_n = 1'b1; m_oe = 1'b0; m_hready = 1'b0;
        m_under = 1'b0; m_over = 1'b0; m_cont = 1'b0;
        m_dout = '0; m_cnt_rd = '0; m_cnt_wr = '0;
    endtask

    // Advances the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit rx_pop, rx_push, tx_push, tx_pop;
        rx_pop  = !rd_n && !oe_n && rxq.size() != 0;
        rx_push = host_in_valid && m_hready;
        tx_push = !wr_n && !m_txe_n;
        tx_pop  = host_out_ready && txq.size() != 0;
        if (!rd_n && !oe_n && rxq.size() == 0) m_under = 1'b1;
        if (!wr_n && m_txe_n) m_over = 1'b1;
        if (!wr_n && m_oe) m_cont = 1'b1;
        if (rx_pop) begin void'(rxq.pop_front()); m_cnt_rd++; end
        if (rx_push) rxq.push_back(host_in_data);
        if (tx_pop) void'(txq.pop_front());
        if (tx_push) begin txq.push_back({be_in, data_in}); m_cnt_wr++; end
        if (rxq.size() != 0) m_dout = rxq[0];
        m_rxf_n  = rxq.size() == 0;
        m_hready = rxq.size() != RXD;
        m_txe_n  = txq.size() == TXD;
        m_oe     = !oe_n;
    endtask

    task automatic check_all();
        chk("rxf_n", rxf_n, m_rxf_n);
        chk("txe_n", txe_n, m_txe_n);
        chk("data_oe", data_oe, m_oe);
        chk("data_out", data_out, m_dout);
        chk("be_out", be_out, 4'hF);
        chk("host_in_ready", host_in_ready, m_hready);
        chk("host_out_valid", host_out_valid, txq.size() != 0);
        if (txq.size() != 0) chk("host_out_data", host_out_data, txq[0]);
        chk("err_underrun", err_underrun, m_under);
        chk("err_overrun", err_overrun, m_over);
        chk("err_contention", err_contention, m_cont);
        chk("cnt_rd", cnt_rd, m_cnt_rd);
        chk("cnt_wr", cnt_wr, m_cnt_wr);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; host_in_valid = 1'b0; host_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        tbl[0] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'd0, 1'b0};
        tbl[1] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'd0, 1'b0};
        tbl[2] = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111, 32'd0, 1'b0};
        tbl[3] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'd0, 1'b0};
        tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 32'd1, 1'b0};
        tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 32'd2, 1'b0};
        tbl[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 32'd3, 1'b0};
        tbl[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h33333333, 32'd3, 1'b0};
        tbl[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 32'd3, 1'b1};
        tbl[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 32'd3, 1'b1};

        model_reset();
        do_reset();
        chk("release txe_n", txe_n, 1'b0);
        chk("release host_in_ready", host_in_ready, 1'b1);

        // RX read burst, then underrun on the emptied FIFO
        foreach (tbl[i]) begin
            host_in_valid = tbl[i].hv; host_in_data = tbl[i].hd;
            oe_n = tbl[i].oe_n; rd_n = tbl[i].rd_n;
            cycle();
            chk($sformatf("tbl%0d rxf_n", i), rxf_n, tbl[i].e_rxf_n);
            chk($sformatf("tbl%0d data_oe", i), data_oe, tbl[i].e_oe);
            chk($sformatf("tbl%0d data_out", i), data_out, tbl[i].e_dout);
            chk($sformatf("tbl%0d cnt_rd", i), cnt_rd, tbl[i].e_cnt);
            chk($sformatf("tbl%0d err_underrun", i), err_underrun, tbl[i].e_under);
        end

        // FPGA writes with mixed byte enables, drained in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_n = 1'b0; data_in = 32'hA0000000 + 32'(i);
            be_in = (i == 1) ? 4'h3 : (i == 3) ? 4'h1 : 4'hF;
            cycle();
        end
        wr_n = 1'b1;
        chk("tx cnt_wr", cnt_wr, 32'd4);
        host_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tx word%0d", i), host_out_data,
                {(i == 1) ? 4'h3 : (i == 3) ? 4'h1 : 4'hF, 32'hA0000000 + 32'(i)});
            cycle();
        end
        chk("tx drained", host_out_valid, 1'b0);
        host_out_ready = 1'b0;

        // TX overflow: six writes into a four-deep FIFO
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_n = 1'b0; data_in = 32'hB0000000 + 32'(i); be_in = 4'hF;
            cycle();
            if (i == 3) chk("txe_n after 4th", txe_n, 1'b1);
        end
        wr_n = 1'b1;
        chk("ovf err_overrun", err_overrun, 1'b1);
        chk("ovf cnt_wr", cnt_wr, 32'd4);
        host_out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 10 && host_out_valid; i++) begin
            pops++;
            cycle();
        end
        chk("ovf drained words", 64'(pops), 64'd4);
        host_out_ready = 1'b0;

        // Streaming at one word per cycle across many pointer wraps
        do_reset();
        host_in_valid = 1'b1; oe_n = 1'b0; rd_n = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            host_in_data = $urandom;
            cycle();
            rd_n = 1'b0;
        end
        host_in_valid = 1'b0;
        cycle();
        rd_n = 1'b1;
        cycle();
        chk("stream cnt_rd", cnt_rd, 32'd5000);
        chk("stream err_underrun", err_underrun, 1'b0);
        chk("stream rxf_n", rxf_n, 1'b1);

        // Fully random traffic on both directions
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            host_in_valid  = $urandom_range(0, 3) != 0;
            host_in_data   = $urandom;
            oe_n           = $urandom_range(0, 3) == 0;
            rd_n           = $urandom_range(0, 2) == 0;
            wr_n           = $urandom_range(0, 1) == 0;
            data_in        = $urandom;
            be_in          = 4'($urandom);
            host_out_ready = $urandom_range(0, 2) != 0;
            cycle();
        end

        // Reset asserted mid-burst with words queued
        do_reset();
        host_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_data = 32'hC0000000 + 32'(i);
            cycle();
        end
        host_in_valid = 1'b0; oe_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; data_in = 32'h5;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post-reset rxf_n", rxf_n, 1'b1);
        chk("post-reset txe_n", txe_n, 1'b0);
        chk("post-reset cnt_rd", cnt_rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
